imem_loader_rom: RTL and testbench

- Instruction-memory responder for the cpu fetch port: takes imem_addr from the core and returns imem_data in the same cycle.
- Contents are filled at runtime through a byte-serial load port with a valid/ready handshake. Bytes are assembled little-endian into 32-bit words and written sequentially from word 0.
- Serves NOP until a load has completed, and while a load is in progress, so the core never fetches undefined data.

---
 rtl/imem_loader_rom.sv | 140 ++++++++++++++
 tb/tb_imem_loader_rom.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_rom.sv
// Instruction ROM for the cpu fetch port, filled at runtime over a byte-serial
// valid/ready load port; serves NOP until a load has completed.
module imem_loader_rom #(
  parameter int          DEPTH = 256,
  parameter int          AW    = 8,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   imem_addr,
  output logic [31:0]   imem_data,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  input  logic          load_end,
  output logic          load_busy,
  output logic          load_err,
  output logic [AW:0]   load_words
);

  typedef enum logic {RUN, LOAD} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic          loaded_q, loaded_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [23:0]   shift_q, shift_d;
  logic          err_q, err_d;
  logic [AW:0]   words_q, words_d;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rd_index;
  logic          in_range;
  logic          unused_addr_lsbs;

  logic [31:0] mem [DEPTH];

  // The write pointer is the complete-word count; it stops advancing once full.
  assign wptr = words_q[AW-1:0];

  // NOTE: every next-state variable gets its hold value first, so no path
  // through the case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    loaded_d  = loaded_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    err_d     = err_q;
    words_d   = words_q;
    mem_we    = 1'b0;
    mem_wdata = {load_data, shift_q};

    unique case (state_q)
      RUN: begin
        if (load_start) begin
          state_d  = LOAD;
          loaded_d = 1'b0;
          bcnt_d   = 2'd0;
          err_d    = 1'b0;
          words_d  = '0;
        end
      end
      LOAD: begin
        if (load_start) begin
          // Restart wins over any byte or load_end presented this cycle.
          bcnt_d  = 2'd0;
          err_d   = 1'b0;
          words_d = '0;
        end else begin
          if (load_valid) begin
            if (bcnt_q == 2'd3) begin
              bcnt_d = 2'd0;
              if (words_q != FULL) begin
                mem_we  = 1'b1;
                words_d = words_q + (AW+1)'(1);
              end else begin
                err_d = 1'b1;
              end
            end else begin
              unique case (bcnt_q)
                2'd0:    shift_d[7:0]   = load_data;
                2'd1:    shift_d[15:8]  = load_data;
                default: shift_d[23:16] = load_data;
              endcase
              bcnt_d = bcnt_q + 2'd1;
            end
          end
          if (load_end) begin
            // A word completed on this same edge leaves bcnt_d at zero: no error.
            if (bcnt_d != 2'd0) err_d = 1'b1;
            bcnt_d   = 2'd0;
            state_d  = RUN;
            loaded_d = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      loaded_q <= 1'b0;
      bcnt_q   <= 2'd0;
      shift_q  <= '0;
      err_q    <= 1'b0;
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      err_q    <= err_d;
      words_q  <= words_d;
    end
  end

  // NOTE: the array has no reset; contents survive rst and are only ever
  // exposed after a completed load, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr] <= mem_wdata;
  end

  assign rd_index         = imem_addr[AW+1:2];
  assign in_range         = (imem_addr[31:AW+2] == '0);
  assign unused_addr_lsbs = ^imem_addr[1:0];

  assign imem_data  = (state_q == RUN && loaded_q && in_range) ? mem[rd_index] : NOP;
  assign load_ready = (state_q == LOAD);
  assign load_busy  = (state_q == LOAD);
  assign load_err   = err_q;
  assign load_words = words_q;

endmodule

// File: tb/tb_imem_loader_rom.sv
// Directed bench for imem_loader_rom: load, fetch decode, error cases,
// overflow and asynchronous reset.
module tb_imem_loader_rom;

  localparam int          DEPTH = 256;
  localparam int          AW    = 8;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr = '0;
  logic [31:0] imem_data;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = '0;
  logic        load_ready;
  logic        load_end = 1'b0;
  logic        load_busy;
  logic        load_err;
  logic [AW:0] load_words;

  int n_cmp = 0;
  int n_bad = 0;

  imem_loader_rom #(.DEPTH(DEPTH), .AW(AW), .NOP(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_end   (load_end),
    .load_busy  (load_busy),
    .load_err   (load_err),
    .load_words (load_words)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after a rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic pulse_end();
    load_end = 1'b1;
    step();
    load_end = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    load_valid = 1'b1;
    load_data  = b;
    step();
    load_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) push(w[8*i +: 8]);
  endtask

  task automatic fetch(input logic [31:0] addr, output logic [31:0] data);
    imem_addr = addr;
    #1;
    data = imem_data;
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    fetch(32'h0, d);
    cmp("reset imem_data", d, NOP);
    cmp("reset load_ready", 32'(load_ready), 32'd0);
    cmp("reset load_busy", 32'(load_busy), 32'd0);
    cmp("reset load_err", 32'(load_err), 32'd0);
    cmp("reset load_words", 32'(load_words), 32'd0);
  endtask

  task automatic test_basic_load();
    logic [7:0] bytes [12] = '{8'h93, 8'h01, 8'h70, 8'h01, 8'h13, 8'h01,
                               8'h30, 8'h01, 8'hb3, 8'h00, 8'h31, 8'h00};
    logic [31:0] d;
    pulse_start();
    for (int i = 0; i < 12; i++) push(bytes[i]);
    pulse_end();
    cmp("basic load_words", 32'(load_words), 32'd3);
    cmp("basic load_err", 32'(load_err), 32'd0);
    cmp("basic load_busy", 32'(load_busy), 32'd0);
    fetch(32'h0, d);  cmp("basic word0", d, 32'h01700193);
    fetch(32'h4, d);  cmp("basic word1", d, 32'h01300113);
    fetch(32'h8, d);  cmp("basic word2", d, 32'h003100b3);
    fetch(32'h5, d);  cmp("basic addr5", d, 32'h01300113);
    fetch(32'h400, d); cmp("out of range 0x400", d, NOP);
    fetch(32'h80000000, d); cmp("out of range msb", d, NOP);
  endtask

  task automatic test_blocking();
    logic [31:0] d;
    pulse_start();
    cmp("load busy", 32'(load_busy), 32'd1);
    cmp("load ready", 32'(load_ready), 32'd1);
    fetch(32'h0, d);
    cmp("fetch during load", d, NOP);
    // RUN ignores stray bytes and load_end
    pulse_end();
    load_valid = 1'b1; load_data = 8'hee; load_end = 1'b1;
    step();
    load_valid = 1'b0; load_end = 1'b0;
    cmp("empty load words", 32'(load_words), 32'd0);
    cmp("empty load err", 32'(load_err), 32'd0);
    cmp("run ready low", 32'(load_ready), 32'd0);
    fetch(32'h0, d);
    cmp("retained word0", d, 32'h01700193);
  endtask

  task automatic test_gaps();
    logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [31:0] d;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      push(bytes[i]);
      step();
    end
    pulse_end();
    cmp("gaps load_words", 32'(load_words), 32'd1);
    cmp("gaps load_err", 32'(load_err), 32'd1);
    fetch(32'h0, d); cmp("gaps word0", d, 32'h44332211);
    fetch(32'h4, d); cmp("gaps word1 untouched", d, 32'h01300113);
  endtask

  task automatic test_end_with_last_byte();
    logic [31:0] d;
    pulse_start();
    cmp("err cleared by start", 32'(load_err), 32'd0);
    push(8'haa); push(8'hbb); push(8'hcc);
    load_valid = 1'b1; load_data = 8'hdd; load_end = 1'b1;
    step();
    load_valid = 1'b0; load_end = 1'b0;
    cmp("end+4th load_words", 32'(load_words), 32'd1);
    cmp("end+4th load_err", 32'(load_err), 32'd0);
    cmp("end+4th busy", 32'(load_busy), 32'd0);
    fetch(32'h0, d); cmp("end+4th word0", d, 32'hddccbbaa);
  endtask

  task automatic test_restart();
    logic [31:0] d;
    pulse_start();
    push(8'h01); push(8'h02);
    // Restart with a byte presented the same cycle: the byte is dropped.
    load_start = 1'b1; load_valid = 1'b1; load_data = 8'h03;
    step();
    load_start = 1'b0; load_valid = 1'b0;
    // Start and end together: start wins.
    load_start = 1'b1; load_end = 1'b1;
    step();
    load_start = 1'b0; load_end = 1'b0;
    cmp("start+end stays busy", 32'(load_busy), 32'd1);
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    pulse_end();
    cmp("restart load_words", 32'(load_words), 32'd1);
    cmp("restart load_err", 32'(load_err), 32'd0);
    fetch(32'h0, d); cmp("restart word0", d, 32'h40302010);
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0]  idx;
    pulse_start();
    for (int w = 0; w < DEPTH; w++) begin
      idx = 8'(w);
      push_word({8'hc3, 8'h5a, ~idx, idx});
    end
    cmp("full load_words", 32'(load_words), 32'(DEPTH));
    cmp("full no err yet", 32'(load_err), 32'd0);
    push_word(32'hdeadbeef);
    cmp("overflow load_err", 32'(load_err), 32'd1);
    cmp("overflow ready", 32'(load_ready), 32'd1);
    cmp("overflow load_words", 32'(load_words), 32'(DEPTH));
    pulse_end();
    fetch(32'h0, d);   cmp("overflow word0", d, 32'hc35aff00);
    fetch(32'h3fc, d); cmp("overflow last word", d, 32'hc35a00ff);
    fetch(32'h1f0, d); cmp("overflow word124", d, 32'hc35a837c);
  endtask

  task automatic test_rst_midload();
    logic [31:0] d;
    pulse_start();
    push(8'h12); push(8'h34);
    #2;
    rst = 1'b1;
    #1;
    cmp("async rst busy", 32'(load_busy), 32'd0);
    cmp("async rst ready", 32'(load_ready), 32'd0);
    fetch(32'h0, d); cmp("async rst fetch", d, NOP);
    step();
    rst = 1'b0;
    step();
    fetch(32'h0, d); cmp("post rst fetch", d, NOP);
    cmp("post rst words", 32'(load_words), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    test_reset();
    test_basic_load();
    test_blocking();
    test_gaps();
    test_end_with_last_byte();
    test_restart();
    test_overflow();
    test_rst_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
